// File: rtl/detect_pkg.sv
// Shared types for the per-frame detection collector: controller states, the stored
// detection entry and the saturating vote counter.
package detect_pkg;

  localparam int unsigned VOTE_MAX    = 255;
  localparam int unsigned DET_COORD_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StScan,
    StDrain,
    StFinish
  } det_state_e;

  typedef struct packed {
    logic [DET_COORD_W-1:0] x;
    logic [DET_COORD_W-1:0] y;
    logic [DET_COORD_W-1:0] scale;
    logic [7:0]             votes;
  } det_entry_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'(VOTE_MAX)) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/det_entry_file.sv
// DEPTH-entry detection register file: one write port, one combinational read port.
// Cleared only by reset; the owner tracks how many entries are valid.
module det_entry_file
  import detect_pkg::*;
#(
  parameter int  DEPTH   = 16,
  parameter int  AW      = $clog2(DEPTH),
  parameter type entry_t = det_entry_t
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  entry_t        wdata_i,
  input  logic [AW-1:0] raddr_i,
  output entry_t        rdata_o
);

  entry_t mem_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Out-of-range reads only occur for non-power-of-two depths and are never consumed.
  assign rdata_o = (32'(raddr_i) < 32'(DEPTH)) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/detection_collector.sv
// Per-frame detection buffer: collects window hits, drains them in insertion order over a
// valid/ready stream and flags overflow. Define DETECT_MERGE_EN to merge near-duplicate hits.
module detection_collector
  import detect_pkg::*;
#(
  parameter int COORD_WIDTH = 8,
  parameter int DEPTH       = 16,
  parameter int MERGE_DIST  = 4,
  parameter int CNT_WIDTH   = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic                   hit_valid,
  output logic                   hit_ready,
  input  logic [COORD_WIDTH-1:0] hit_x,
  input  logic [COORD_WIDTH-1:0] hit_y,
  input  logic [COORD_WIDTH-1:0] hit_scale,
  input  logic                   frame_done,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COORD_WIDTH-1:0] out_x,
  output logic [COORD_WIDTH-1:0] out_y,
  output logic [COORD_WIDTH-1:0] out_scale,
  output logic [7:0]             out_votes,
  output logic [CNT_WIDTH-1:0]   count,
  output logic                   overflow,
  output logic                   busy,
  output logic                   done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [COORD_WIDTH-1:0] x;
    logic [COORD_WIDTH-1:0] y;
    logic [COORD_WIDTH-1:0] scale;
    logic [7:0]             votes;
  } entry_t;

  det_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                 overflow_q, overflow_d;

  logic          we;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;
  entry_t        wdata;
  entry_t        rd_entry;
  entry_t        hit_entry;

  assign hit_entry = '{x: hit_x, y: hit_y, scale: hit_scale, votes: 8'd1};

`ifdef DETECT_MERGE_EN
  logic [CNT_WIDTH-1:0] scan_q, scan_d;
  logic                 pend_q, pend_d;
  entry_t               cap_q, cap_d;
  logic [COORD_WIDTH:0] dx, dy, adx, ady;
  logic                 match;
  logic                 scan_end;

  assign dx    = {1'b0, cap_q.x} - {1'b0, rd_entry.x};
  assign dy    = {1'b0, cap_q.y} - {1'b0, rd_entry.y};
  assign adx   = dx[COORD_WIDTH] ? -dx : dx;
  assign ady   = dy[COORD_WIDTH] ? -dy : dy;
  assign match = (cap_q.scale == rd_entry.scale) &&
                 (adx <= (COORD_WIDTH + 1)'(MERGE_DIST)) &&
                 (ady <= (COORD_WIDTH + 1)'(MERGE_DIST));
`else
  logic unused_merge_dist;
  assign unused_merge_dist = ^32'(MERGE_DIST);
`endif

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    we         = 1'b0;
    waddr      = count_q[AW-1:0];
    wdata      = hit_entry;
    raddr      = rd_ptr_q[AW-1:0];
    hit_ready  = 1'b0;
    out_valid  = 1'b0;
    done       = 1'b0;
`ifdef DETECT_MERGE_EN
    scan_d     = scan_q;
    pend_d     = pend_q;
    cap_d      = cap_q;
    scan_end   = 1'b0;
`endif

    unique case (state_q)
      StIdle: ;
      StCollect: begin
        hit_ready = 1'b1;
`ifdef DETECT_MERGE_EN
        if (hit_valid) begin
          cap_d   = hit_entry;
          scan_d  = '0;
          pend_d  = frame_done;
          state_d = StScan;
        end else if (frame_done) begin
          rd_ptr_d = '0;
          state_d  = (count_q == '0) ? StFinish : StDrain;
        end
`else
        if (hit_valid) begin
          if (count_q < CNT_WIDTH'(DEPTH)) begin
            we      = 1'b1;
            count_d = count_q + CNT_WIDTH'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
        // The hit in the same cycle is already reflected in count_d.
        if (frame_done) begin
          rd_ptr_d = '0;
          state_d  = (count_d == '0) ? StFinish : StDrain;
        end
`endif
      end
`ifdef DETECT_MERGE_EN
      StScan: begin
        raddr = scan_q[AW-1:0];
        if (scan_q == count_q) begin
          scan_end = 1'b1;
          wdata    = cap_q;
          if (count_q < CNT_WIDTH'(DEPTH)) begin
            we      = 1'b1;
            count_d = count_q + CNT_WIDTH'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end else if (match) begin
          scan_end    = 1'b1;
          we          = 1'b1;
          waddr       = scan_q[AW-1:0];
          wdata       = rd_entry;
          wdata.votes = sat_inc(rd_entry.votes);
        end else begin
          scan_d = scan_q + CNT_WIDTH'(1);
        end
        if (frame_done) begin
          pend_d = 1'b1;
        end
        if (scan_end) begin
          if (pend_d) begin
            pend_d   = 1'b0;
            rd_ptr_d = '0;
            state_d  = (count_d == '0) ? StFinish : StDrain;
          end else begin
            state_d = StCollect;
          end
        end
      end
`endif
      StDrain: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (rd_ptr_q + CNT_WIDTH'(1) == count_q) begin
            state_d = StFinish;
          end else begin
            rd_ptr_d = rd_ptr_q + CNT_WIDTH'(1);
          end
        end
      end
      StFinish: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A new frame wins over any hit or frame_done in the same cycle.
    if (frame_start) begin
      state_d    = StCollect;
      count_d    = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
      we         = 1'b0;
`ifdef DETECT_MERGE_EN
      pend_d     = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
`ifdef DETECT_MERGE_EN
      scan_q     <= '0;
      pend_q     <= 1'b0;
      cap_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
`ifdef DETECT_MERGE_EN
      scan_q     <= scan_d;
      pend_q     <= pend_d;
      cap_q      <= cap_d;
`endif
    end
  end

  det_entry_file #(
    .DEPTH   (DEPTH),
    .AW      (AW),
    .entry_t (entry_t)
  ) u_entry_file (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (raddr),
    .rdata_o (rd_entry)
  );

  assign out_x     = out_valid ? rd_entry.x     : '0;
  assign out_y     = out_valid ? rd_entry.y     : '0;
  assign out_scale = out_valid ? rd_entry.scale : '0;
  assign out_votes = out_valid ? rd_entry.votes : '0;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_detection_collector.sv
// Randomized scoreboard bench for detection_collector; the model follows DETECT_MERGE_EN.
module tb_detection_collector;

  localparam int CW    = 8;
  localparam int DEPTH = 16;
  localparam int MD    = 4;
  localparam int CNTW  = $clog2(DEPTH + 1);
`ifdef DETECT_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            frame_start = 1'b0;
  logic            hit_valid = 1'b0;
  logic            hit_ready;
  logic [CW-1:0]   hit_x = '0, hit_y = '0, hit_scale = '0;
  logic            frame_done = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [CW-1:0]   out_x, out_y, out_scale;
  logic [7:0]      out_votes;
  logic [CNTW-1:0] count;
  logic            overflow, busy, done;

  detection_collector #(
    .COORD_WIDTH (CW),
    .DEPTH       (DEPTH),
    .MERGE_DIST  (MD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .hit_valid   (hit_valid),
    .hit_ready   (hit_ready),
    .hit_x       (hit_x),
    .hit_y       (hit_y),
    .hit_scale   (hit_scale),
    .frame_done  (frame_done),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_scale   (out_scale),
    .out_votes   (out_votes),
    .count       (count),
    .overflow    (overflow),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; int s; int v;} ent_t;

  ent_t m_q[$];    // model buffer for the current frame
  ent_t exp_q[$];  // scoreboard of expected drain beats
  bit   m_ovf;
  int   n_tests = 0, n_fail = 0;
  int   cyc = 0, last_ev = -10, done_cnt = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic model_hit(input int x, input int y, input int s);
    bit merged = 1'b0;
    if (MERGE) begin
      foreach (m_q[i]) begin
        if (!merged && m_q[i].s == s && absd(m_q[i].x, x) <= MD && absd(m_q[i].y, y) <= MD) begin
          m_q[i].v = (m_q[i].v >= 255) ? 255 : m_q[i].v + 1;
          merged = 1'b1;
        end
      end
    end
    if (!merged) begin
      if (m_q.size() < DEPTH) m_q.push_back('{x, y, s, 1});
      else m_ovf = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every beat, checks stall stability and done timing.
  ent_t        mon_e;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_bus;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("stall_hold", {out_valid, out_x, out_y, out_scale, out_votes} == {1'b1, prev_bus}, 1);
      if (out_valid && out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL beat: unexpected (%0d,%0d,%0d,v%0d) with nothing pending", out_x, out_y, out_scale, out_votes);
        end else begin
          mon_e = exp_q.pop_front();
          if (out_x != mon_e.x || out_y != mon_e.y || out_scale != mon_e.s || out_votes != mon_e.v) begin
            n_fail++;
            $display("FAIL beat: got (%0d,%0d,%0d,v%0d) expected (%0d,%0d,%0d,v%0d)", out_x, out_y, out_scale,
                     out_votes, mon_e.x, mon_e.y, mon_e.s, mon_e.v);
          end
        end
        last_ev = cyc;
      end
      if (frame_done && busy) last_ev = (last_ev > cyc) ? last_ev : cyc;
      if (done) begin
        check("done_timing", cyc, last_ev + 1);
        check("done_count", count, m_q.size());
        check("done_ovf", overflow, m_ovf);
        done_cnt++;
      end
      prev_stall = out_valid && !out_ready && !frame_start;
      prev_bus   = {out_x, out_y, out_scale, out_votes};
    end
  end

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    m_q.delete();
    m_ovf = 1'b0;
    check("start_count", count, 0);
    check("start_ovf", overflow, 0);
    check("start_ready", hit_ready, 1);
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 100 && !hit_ready; k++) tick();
    check("ready_timeout", hit_ready, 1);
  endtask

  task automatic send_hit(input int x, input int y, input int s, input int gap);
    wait_ready();
    hit_x = CW'(x); hit_y = CW'(y); hit_scale = CW'(s);
    hit_valid = 1'b1;
    tick();
    hit_valid = 1'b0;
    model_hit(x, y, s);
    check("ready_after_hit", hit_ready, MERGE ? 0 : 1);
    for (int k = 0; k < gap; k++) tick();
  endtask

  function automatic logic rdy_of(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return 1'($urandom_range(0, 1));
      default: return (k % 4 == 0) || (k % 4 == 3);
    endcase
  endfunction

  task automatic end_frame(input int mode, input bit with_hit, input int x, input int y, input int s);
    int d0;
    wait_ready();
    d0 = done_cnt;
    if (with_hit) begin
      hit_x = CW'(x); hit_y = CW'(y); hit_scale = CW'(s);
      hit_valid = 1'b1;
    end
    out_ready  = rdy_of(mode, 0);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    hit_valid  = 1'b0;
    if (with_hit) model_hit(x, y, s);
    foreach (m_q[i]) exp_q.push_back(m_q[i]);
    if (!(MERGE && with_hit)) check("first_valid", out_valid, m_q.size() > 0);
    for (int k = 1; k < 400 && done_cnt == d0; k++) begin
      out_ready = rdy_of(mode, k);
      tick();
    end
    check("done_seen", done_cnt, d0 + 1);
    check("drain_left", exp_q.size(), 0);
    check("idle_busy", busy, 0);
    check("end_count", count, m_q.size());
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    tick();
    tick();
    check("rst_outs", {hit_ready, out_valid, out_x, out_y, out_scale, out_votes, count, overflow, busy, done} == '0, 1);
    rst = 1'b0;
    tick();
    check("idle_ready", hit_ready, 0);
    check("idle_busy0", busy, 0);

    // Three hits, drained with out_ready high.
    start_frame();
    send_hit(10, 10, 1, 0);
    send_hit(40, 20, 2, 0);
    send_hit(5, 50, 1, 0);
    end_frame(0, 1'b0, 0, 0, 0);
    check("three_count", count, 3);

    // Overflow: 18 well-separated hits.
    start_frame();
    for (int i = 0; i < 18; i++) send_hit(i * 10, i, 3, 0);
    check("ovf_count", count, 16);
    check("ovf_flag", overflow, 1);
    end_frame(0, 1'b0, 0, 0, 0);

    // Empty frame.
    start_frame();
    end_frame(0, 1'b0, 0, 0, 0);

    // Stall pattern 1,0,0,1.
    start_frame();
    for (int i = 0; i < 5; i++) send_hit(i * 20 + 3, 200 - i * 15, i, 1);
    end_frame(2, 1'b0, 0, 0, 0);

    // frame_start mid-drain with a simultaneous hit.
    start_frame();
    for (int i = 0; i < 17; i++) send_hit(i * 12, 7, 1, 0);
    wait_ready();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    foreach (m_q[i]) exp_q.push_back(m_q[i]);
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    hit_x = 8'd99; hit_y = 8'd99; hit_scale = 8'd1;
    hit_valid = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    hit_valid = 1'b0;
    exp_q.delete();
    m_q.delete();
    m_ovf = 1'b0;
    check("fs_count", count, 0);
    check("fs_ovf", overflow, 0);
    check("fs_collect", {busy, hit_ready, out_valid}, 3'b110);
    tick();
    check("fs_discard", count, 0);
    end_frame(0, 1'b0, 0, 0, 0);

    // Asynchronous reset mid-collect.
    start_frame();
    for (int i = 0; i < 3; i++) send_hit(i * 30, 1, 0, 0);
    rst = 1'b1;
    #1;
    check("rst_mid", {hit_ready, out_valid, out_x, out_y, out_scale, out_votes, count, overflow, busy, done} == '0, 1);
    tick();
    rst = 1'b0;
    m_q.delete();
    m_ovf = 1'b0;
    tick();

    // Near-duplicate hits.
    start_frame();
    send_hit(20, 20, 1, 0);
    send_hit(23, 18, 1, 0);
    send_hit(30, 20, 1, 0);
    send_hit(20, 20, 2, 0);
    end_frame(0, 1'b0, 0, 0, 0);

    // Random frames in a small coordinate space so merges are common.
    for (int f = 0; f < 8; f++) begin
      start_frame();
      n = $urandom_range(0, 22);
      for (int i = 0; i < n; i++)
        send_hit($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 2));
      end_frame($urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
